// File: rtl/atm_pkg.sv
// Shared definitions for the ATM keypad controller.
//   AMT_W      : width of the binary request amount
//   KEY_ENTER  : key code for ENTER
//   KEY_CANCEL : key code for CANCEL
//   state_e    : controller FSM states
//   is_digit   : true for key codes 0-9
package atm_pkg;

  localparam int AMT_W = 8;

  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CANCEL = 4'hB;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PIN,
    ST_CHECK,
    ST_AMOUNT,
    ST_ISSUE,
    ST_LOCKED
  } state_e;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/atm_bcd_accum.sv
// Saturating decimal amount accumulator.
// Each accepted digit updates value <= value*10 + digit, evaluated at 12 bits
// and clamped to 255.
//   clk         : system clock, rising edge
//   rst         : synchronous active-high reset, clears value
//   clear       : synchronous clear of the accumulated value (wins over digit)
//   digit_valid : digit is to be accumulated this cycle
//   digit       : decimal digit 0-9
//   value       : registered accumulated amount
module atm_bcd_accum
  import atm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  output logic [AMT_W-1:0] value
);

  logic [AMT_W-1:0] value_q;
  logic [11:0]      next_wide;

  // 255*10+9 = 2559 fits in 12 bits, so the widened product never wraps.
  function automatic logic [AMT_W-1:0] sat_amt(input logic [11:0] x);
    if (x > 12'd255) begin
      return {AMT_W{1'b1}};
    end
    return x[AMT_W-1:0];
  endfunction

  assign next_wide = ({4'b0, value_q} * 12'd10) + {8'b0, digit};

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else if (clear) begin
      value_q <= '0;
    end else if (digit_valid) begin
      value_q <= sat_amt(next_wide);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/atm_keypad_ctrl.sv
// ATM keypad session controller: face-gated session, 4-digit PIN entry and
// check with lockout, decimal amount entry, and a valid/ready request to the
// downstream ATM stage.
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   face       : customer present; a session runs only while high
//   key_valid  : one-cycle strobe qualifying key_code
//   key_code   : 0-9 digit, A ENTER, B CANCEL, C-F ignored
//   req_valid  : request valid towards downstream (registered)
//   req_ready  : downstream accepts the request
//   req_amount : requested amount, binary (registered)
//   pin_error  : one-cycle pulse per wrong PIN (registered)
//   locked     : lockout flag (registered)
//   busy       : high in every state except IDLE (registered)
module atm_keypad_ctrl
  import atm_pkg::*;
#(
  parameter logic [15:0] PIN_CODE    = 16'h1234,
  parameter int          MAX_TRIES   = 3,
  parameter int          TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             face,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [AMT_W-1:0] req_amount,
  output logic             pin_error,
  output logic             locked,
  output logic             busy
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES + 1) : 1;

  state_e           state_q;
  logic [15:0]      pin_q;
  logic [2:0]       cnt_q;
  logic [TRY_W-1:0] tries_q;
  logic [TMO_W-1:0] tmo_q;
  logic             req_valid_q;
  logic [AMT_W-1:0] req_amount_q;
  logic             pin_error_q;
  logic             locked_q;
  logic             busy_q;

  logic             key_digit;
  logic             key_enter;
  logic             key_cancel;
  logic             tmo_hit;
  logic             pin_match;
  logic             abort;
  logic             amt_clear;
  logic             amt_digit;
  logic [AMT_W-1:0] amt_value;

  assign key_digit  = key_valid && is_digit(key_code);
  assign key_enter  = key_valid && (key_code == KEY_ENTER);
  assign key_cancel = key_valid && (key_code == KEY_CANCEL);

  // The idle counter holds the number of keyless cycles already spent; the
  // current keyless cycle is the TIMEOUT_CYC-th when it reads TIMEOUT_CYC-1.
  assign tmo_hit   = !key_valid && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
  // A short entry never matches even if the shifted bits happen to agree.
  assign pin_match = (cnt_q == 3'd4) && (pin_q == PIN_CODE);
  // Face drop is checked first so it wins over a coincident key.
  assign abort     = !face || key_cancel || tmo_hit;

  // The accumulator only lives while in AMOUNT; any other state empties it,
  // so every exit from AMOUNT leaves it cleared for the next session.
  assign amt_clear = (state_q != ST_AMOUNT);
  assign amt_digit = (state_q == ST_AMOUNT) && face && key_digit;

  atm_bcd_accum u_accum (
    .clk         (clk),
    .rst         (rst),
    .clear       (amt_clear),
    .digit_valid (amt_digit),
    .digit       (key_code),
    .value       (amt_value)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pin_q        <= '0;
      cnt_q        <= '0;
      tries_q      <= '0;
      tmo_q        <= '0;
      req_valid_q  <= 1'b0;
      req_amount_q <= '0;
      pin_error_q  <= 1'b0;
      locked_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      pin_error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (face) begin
            state_q <= ST_PIN;
            busy_q  <= 1'b1;
            pin_q   <= '0;
            cnt_q   <= '0;
            tries_q <= '0;
            tmo_q   <= '0;
          end
        end

        ST_PIN: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            pin_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
          end else begin
            tmo_q <= key_valid ? '0 : tmo_q + TMO_W'(1);
            if (key_digit && (cnt_q != 3'd4)) begin
              pin_q <= {pin_q[11:0], key_code};
              cnt_q <= cnt_q + 3'd1;
            end
            if (key_enter) begin
              state_q <= ST_CHECK;
            end
          end
        end

        ST_CHECK: begin
          tmo_q <= '0;
          if (pin_match) begin
            tries_q <= '0;
            state_q <= ST_AMOUNT;
          end else begin
            pin_error_q <= 1'b1;
            pin_q       <= '0;
            cnt_q       <= '0;
            if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
              state_q  <= ST_LOCKED;
              locked_q <= 1'b1;
            end else begin
              tries_q <= tries_q + TRY_W'(1);
              state_q <= ST_PIN;
            end
          end
        end

        ST_AMOUNT: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            tmo_q   <= '0;
          end else begin
            tmo_q <= key_valid ? '0 : tmo_q + TMO_W'(1);
            if (key_enter && (amt_value != '0)) begin
              state_q      <= ST_ISSUE;
              req_valid_q  <= 1'b1;
              req_amount_q <= amt_value;
            end
          end
        end

        ST_ISSUE: begin
          // Keys, face and timeout are deliberately ignored: once offered,
          // the request stays until the downstream stage takes it.
          if (req_ready) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            req_valid_q  <= 1'b0;
            req_amount_q <= '0;
          end
        end

        ST_LOCKED: begin
          locked_q <= 1'b1;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_valid  = req_valid_q;
  assign req_amount = req_amount_q;
  assign pin_error  = pin_error_q;
  assign locked     = locked_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_atm_keypad_ctrl.sv
module tb_atm_keypad_ctrl;

  localparam logic [15:0] PIN  = 16'h1234;
  localparam int          MAXT = 3;
  localparam int          TMO  = 1000;
  localparam int          ENT  = 10;
  localparam int          CAN  = 11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       face = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       req_ready = 1'b0;
  logic       req_valid;
  logic [7:0] req_amount;
  logic       pin_error;
  logic       locked;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int pe_cnt = 0;

  always #5 clk = ~clk;

  atm_keypad_ctrl #(
    .PIN_CODE    (PIN),
    .MAX_TRIES   (MAXT),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .face       (face),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_amount (req_amount),
    .pin_error  (pin_error),
    .locked     (locked),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 entering pin, 2 checking, 3 entering amount,
  //        4 offering request, 5 locked out
  function automatic int bcd2int(input logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  int m_phase = 0;
  int m_digs[$];
  int m_tries = 0;
  int m_amt = 0;
  int m_idle = 0;
  int m_kc;
  int m_val;
  bit m_kv;
  bit m_rv = 0;
  int m_ra = 0;
  bit m_pe = 0;
  bit m_lk = 0;
  bit m_busy = 0;

  always @(posedge clk) begin : model
    m_kv = key_valid;
    m_kc = int'(key_code);
    m_pe = 1'b0;
    if (rst) begin
      m_phase = 0; m_digs.delete(); m_tries = 0; m_amt = 0; m_idle = 0;
      m_rv = 0; m_ra = 0; m_lk = 0;
    end else begin
      case (m_phase)
        0: if (face) begin
             m_phase = 1; m_digs.delete(); m_tries = 0; m_amt = 0; m_idle = 0;
           end
        1, 3: begin
          if (!face || (m_kv && m_kc == CAN) || (!m_kv && m_idle == TMO - 1)) begin
            m_phase = 0; m_digs.delete(); m_amt = 0; m_idle = 0;
          end else begin
            m_idle = m_kv ? 0 : m_idle + 1;
            if (m_kv && m_kc <= 9) begin
              if (m_phase == 1 && m_digs.size() < 4) m_digs.push_back(m_kc);
              if (m_phase == 3) m_amt = (m_amt * 10 + m_kc > 255) ? 255 : m_amt * 10 + m_kc;
            end
            if (m_kv && m_kc == ENT) begin
              if (m_phase == 1) m_phase = 2;
              else if (m_amt > 0) begin m_phase = 4; m_rv = 1; m_ra = m_amt; end
            end
          end
        end
        2: begin
          m_val = 0;
          foreach (m_digs[i]) m_val = m_val * 10 + m_digs[i];
          m_idle = 0;
          if (m_digs.size() == 4 && m_val == bcd2int(PIN)) begin
            m_tries = 0; m_amt = 0; m_phase = 3;
          end else begin
            m_pe = 1; m_tries++; m_digs.delete();
            if (m_tries >= MAXT) begin m_phase = 5; m_lk = 1; end
            else m_phase = 1;
          end
        end
        4: if (req_ready) begin m_phase = 0; m_rv = 0; m_ra = 0; end
        default: ;
      endcase
    end
    m_busy = (m_phase != 0);
  end

  always @(posedge clk) begin : compare
    #2;
    chk("req_valid", req_valid, 32'(m_rv));
    chk("req_amount", req_amount, 32'(m_ra));
    chk("pin_error", pin_error, 32'(m_pe));
    chk("locked", locked, 32'(m_lk));
    chk("busy", busy, 32'(m_busy));
    if (pin_error === 1'b1) pe_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic key(input int k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'(k);
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic enter_pin();
    key(1); key(2); key(3); key(4); key(ENT);
  endtask

  task automatic do_rst(input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk({tag, "_rv"}, req_valid, 0);
    chk({tag, "_ra"}, req_amount, 0);
    chk({tag, "_pe"}, pin_error, 0);
    chk({tag, "_lk"}, locked, 0);
    chk({tag, "_busy"}, busy, 0);
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int pe_base;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_locked", locked, 0);
    chk("reset_rv", req_valid, 0);
    rst = 1'b0;

    // Normal withdrawal of 50
    req_ready = 1'b1;
    face = 1'b1;
    enter_pin();
    key(5); key(0); key(ENT);
    chk("s1_rv", req_valid, 1);
    chk("s1_amount", req_amount, 50);
    face = 1'b0;
    @(negedge clk);
    chk("s1_rv_after", req_valid, 0);
    chk("s1_busy_after", busy, 0);
    chk("s1_no_pe", pe_cnt, 0);

    // Three wrong PINs -> lockout
    pe_base = pe_cnt;
    face = 1'b1;
    for (int t = 0; t < 3; t++) begin
      key(1); key(2); key(3); key(5); key(ENT);
      chk("s2_pe_plus1", pin_error, 0);
      @(negedge clk);
      chk("s2_pe_plus2", pin_error, 1);
      chk("s2_locked", locked, (t == 2) ? 1 : 0);
    end
    chk("s2_pe_count", pe_cnt - pe_base, 3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      key_valid = 1'($urandom_range(0, 1));
      key_code  = 4'($urandom_range(0, 15));
      face      = 1'($urandom_range(0, 1));
    end
    key_valid = 1'b0;
    face = 1'b1;
    @(negedge clk);
    chk("s2_still_locked", locked, 1);
    chk("s2_busy_locked", busy, 1);
    do_rst("rst_locked");
    face = 1'b0;
    @(negedge clk);

    // Ignored key code in PIN, saturated amount
    face = 1'b1;
    key(1); key(2); key(12); key(3); key(4); key(ENT);
    key(9); key(9); key(9); key(ENT);
    chk("s3_rv", req_valid, 1);
    chk("s3_amount_sat", req_amount, 255);
    face = 1'b0;
    @(negedge clk);

    // Fifth PIN digit ignored; stall in ISSUE with noisy inputs
    req_ready = 1'b0;
    face = 1'b1;
    key(1); key(2); key(3); key(4); key(9); key(ENT);
    key(4); key(2); key(ENT);
    for (int i = 0; i < 20; i++) begin
      chk("s4_rv_hold", req_valid, 1);
      chk("s4_amt_hold", req_amount, 42);
      @(negedge clk);
      key_valid = 1'($urandom_range(0, 1));
      key_code  = 4'($urandom_range(0, 15));
      face      = 1'($urandom_range(0, 1));
    end
    key_valid = 1'b0;
    face = 1'b0;
    req_ready = 1'b1;
    @(negedge clk);
    chk("s4_rv_done", req_valid, 0);
    chk("s4_busy_done", busy, 0);

    // Idle timeout
    face = 1'b1;
    repeat (TMO) @(negedge clk);
    chk("s5_busy_before_tmo", busy, 1);
    @(negedge clk);
    chk("s5_busy_after_tmo", busy, 0);
    face = 1'b0;
    @(negedge clk);

    // CANCEL in AMOUNT clears the amount
    face = 1'b1;
    enter_pin();
    key(7); key(CAN);
    chk("s5_cancel_idle", busy, 0);
    enter_pin();
    key(ENT);
    chk("s5_zero_enter_rv", req_valid, 0);
    chk("s5_zero_enter_busy", busy, 1);
    key(3); key(ENT);
    chk("s5_amount_cleared", req_amount, 3);
    face = 1'b0;
    @(negedge clk);

    // Reset in the middle of ISSUE
    req_ready = 1'b0;
    face = 1'b1;
    enter_pin();
    key(8); key(ENT);
    chk("s6_rv", req_valid, 1);
    do_rst("rst_issue");
    face = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
